// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port owner
// and the default datapath width.
package mem_arb_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating response-wait counter. expired rises on the TIMEOUT-th
// enabled cycle after a clear, so it can terminate the wait that cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (clear) begin
      cnt_p0 <= '0;
    end else if (enable && (cnt_p0 != CNT_MAX)) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // The current cycle counts toward the limit, hence compare against TIMEOUT-1.
  assign expired = enable & (cnt_p0 >= CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// MEM stage; data side has fixed priority, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_be,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);

  arb_state_t      state_p0;
  arb_owner_t      owner_p0;
  logic            killed_p0;
  logic            req_we_p0;
  logic [3:0]      req_be_p0;
  logic [XLEN-1:0] req_addr_p0;
  logic [XLEN-1:0] req_wdata_p0;

  logic            in_idle;
  logic            in_req;
  logic            in_resp;
  logic            expired;
  logic            done;
  logic            timed_out;
  logic            take_dm;
  logic            take_if;
  logic [XLEN-1:0] rsp_data;

  assign in_idle = (state_p0 == IDLE);
  assign in_req  = (state_p0 == REQ);
  assign in_resp = (state_p0 == RESP);
  assign take_dm = in_idle & dm_req;
  assign take_if = in_idle & ~dm_req & if_req & ~if_kill;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_req & mem_ready),
    .enable  (in_resp),
    .expired (expired)
  );

  assign timed_out = in_resp & expired & ~mem_rvalid;
  assign done      = in_resp & (mem_rvalid | expired);

  // Stage p0: arbitration FSM, owner and kill tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0  <= IDLE;
      owner_p0  <= OWN_IF;
      killed_p0 <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (take_dm) begin
            owner_p0 <= OWN_DM;
            state_p0 <= REQ;
          end else if (take_if) begin
            owner_p0 <= OWN_IF;
            state_p0 <= REQ;
          end
        end
        REQ:     if (mem_ready) state_p0 <= RESP;
        RESP:    if (done) state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase

      // A killed fetch still runs to completion on the bus; only its ack is dropped.
      if (in_idle || done) begin
        killed_p0 <= 1'b0;
      end else if (if_kill && (owner_p0 == OWN_IF)) begin
        killed_p0 <= 1'b1;
      end
    end
  end

  // Stage p0: request registers, captured once per transaction in IDLE
  always_ff @(posedge clk) begin
    if (take_dm) begin
      req_we_p0    <= dm_we;
      req_be_p0    <= dm_be;
      req_addr_p0  <= dm_addr;
      req_wdata_p0 <= dm_wdata;
    end else if (take_if) begin
      req_we_p0    <= 1'b0;
      req_be_p0    <= 4'hF;
      req_addr_p0  <= if_addr;
      req_wdata_p0 <= '0;
    end
  end

  assign mem_req   = in_req;
  assign mem_we    = in_req & req_we_p0;
  assign mem_be    = in_req ? req_be_p0    : 4'h0;
  assign mem_addr  = in_req ? req_addr_p0  : '0;
  assign mem_wdata = in_req ? req_wdata_p0 : '0;

  assign rsp_data  = timed_out ? '0 : mem_rdata;

  assign if_ack    = done & (owner_p0 == OWN_IF) & ~killed_p0 & ~if_kill;
  assign dm_ack    = done & (owner_p0 == OWN_DM);
  assign if_rdata  = if_ack ? rsp_data : '0;
  assign dm_rdata  = dm_ack ? rsp_data : '0;
  assign bus_err   = timed_out;

  assign stall_if  = if_req & ~if_ack & ~if_kill;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// and a programmable memory responder.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_kill, if_ack;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            dm_req, dm_we, dm_ack;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_addr, dm_wdata, dm_rdata;
  logic            mem_req, mem_we, mem_ready, mem_rvalid;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic            stall_if, stall_mem, bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        own_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t  exp_q[$];
  txn_t  cur;
  logic  cur_valid, kill_flag, chk_en;
  int    n_chk, n_fail;

  int          ready_delay, rvalid_delay, req_cyc, k_m;
  logic [31:0] rd_val;
  logic        force_rvalid, rv_m, in_resp_m, acc_prev, done_prev, timeout_m, done_m;

  assign mem_rvalid = rv_m | force_rvalid;
  assign mem_rdata  = rd_val;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return if_ack;
      1:       return dm_ack;
      default: return mem_req;
    endcase
  endfunction

  // n = number of negedges sampled until the signal was seen (sampling point included)
  task automatic wait_for(input string name, input int which, input int max, output int n);
    n = 0;
    forever begin
      smp();
      n++;
      if (sel(which)) return;
      if (n >= max) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles", name, n);
        n = -1;
        return;
      end
      tick();
    end
  endtask

  function automatic txn_t mk(input logic d, input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.own_dm = d; t.we = we; t.be = be; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  // Memory responder: accepts after ready_delay REQ cycles, answers on RESP cycle rvalid_delay
  initial begin
    mem_ready = 1'b0; rv_m = 1'b0; in_resp_m = 1'b0; k_m = 0; req_cyc = 0;
    acc_prev = 1'b0; done_prev = 1'b0; timeout_m = 1'b0; done_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_resp_m = 1'b0; acc_prev = 1'b0; done_prev = 1'b0; req_cyc = 0; k_m = 0;
        mem_ready = 1'b0; rv_m = 1'b0; timeout_m = 1'b0; done_m = 1'b0;
      end else begin
        if (acc_prev) begin
          in_resp_m = 1'b1;
          k_m = 0;
        end else if (in_resp_m) begin
          if (done_prev) in_resp_m = 1'b0;
          else k_m++;
        end
        if (mem_req) begin
          mem_ready = (req_cyc == ready_delay);
          req_cyc++;
        end else begin
          mem_ready = 1'b0;
          req_cyc = 0;
        end
        rv_m      = in_resp_m && (k_m == rvalid_delay);
        timeout_m = in_resp_m && (k_m != rvalid_delay) && (k_m == TO - 1);
        done_m    = rv_m || timeout_m;
        acc_prev  = mem_ready;
        done_prev = done_m;
      end
    end
  end

  // Reference model compare: checks outputs every cycle against the expected transaction stream
  logic        e_if_ack, e_dm_ack;
  logic [31:0] e_rd;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (if_kill && ((cur_valid && !cur.own_dm) ||
                      (mem_req && exp_q.size() > 0 && !exp_q[0].own_dm)))
        kill_flag = 1'b1;
      e_if_ack = done_m && cur_valid && !cur.own_dm && !kill_flag;
      e_dm_ack = done_m && cur_valid && cur.own_dm;
      e_rd     = timeout_m ? 32'h0 : mem_rdata;
      chk1("if_ack", if_ack, e_if_ack);
      chk1("dm_ack", dm_ack, e_dm_ack);
      chk1("bus_err", bus_err, timeout_m);
      if (e_if_ack) chk32("if_rdata", if_rdata, e_rd);
      if (e_dm_ack) chk32("dm_rdata", dm_rdata, e_rd);
      chk1("stall_if", stall_if, if_req & ~e_if_ack & ~if_kill);
      chk1("stall_mem", stall_mem, dm_req & ~e_dm_ack);
      if (done_m && !cur_valid) chk1("completion without transaction", 1'b0, 1'b1);
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected mem_req", mem_req, 1'b0);
        end else begin
          chk1("mem_we", mem_we, exp_q[0].we);
          chk32("mem_be", 32'(mem_be), 32'(exp_q[0].be));
          chk32("mem_addr", mem_addr, exp_q[0].addr);
          if (exp_q[0].we) chk32("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (mem_req && mem_ready && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        cur_valid = 1'b1;
      end
      if (done_m) begin
        cur_valid = 1'b0;
        kill_flag = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  int n, stall_cnt, req_cnt;
  logic got_ack;

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0; cur_valid = 1'b0; kill_flag = 1'b0;
    rst = 1'b1; if_req = 1'b1; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h0; dm_addr = '0; dm_wdata = '0;
    ready_delay = 0; rvalid_delay = 0; rd_val = 32'h0; force_rvalid = 1'b0;

    // Reset state
    #2;
    chk1("rst mem_req", mem_req, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk32("rst mem_be", 32'(mem_be), 32'h0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk1("rst if_ack", if_ack, 1'b0);
    chk1("rst dm_ack", dm_ack, 1'b0);
    chk1("rst bus_err", bus_err, 1'b0);
    chk32("rst if_rdata", if_rdata, 32'h0);
    chk32("rst dm_rdata", dm_rdata, 32'h0);
    chk1("rst stall_if", stall_if, 1'b1);
    chk1("rst stall_mem", stall_mem, 1'b1);
    tick(); if_req = 1'b0; dm_req = 1'b0;
    tick(); rst = 1'b0; chk_en = 1'b1;
    tick(); tick();

    // Single load, best-case latency
    rd_val = 32'hDEADBEEF; ready_delay = 0; rvalid_delay = 0;
    exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h100, 32'h0));
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h100; dm_wdata = 32'h0;
    smp(); chk1("t1 c0 mem_req", mem_req, 1'b0); chk1("t1 c0 stall_mem", stall_mem, 1'b1);
    tick(); smp();
    chk1("t1 c1 mem_req", mem_req, 1'b1); chk32("t1 c1 mem_addr", mem_addr, 32'h100);
    chk1("t1 c1 stall_mem", stall_mem, 1'b1);
    tick(); smp();
    chk1("t1 c2 dm_ack", dm_ack, 1'b1); chk32("t1 c2 dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk1("t1 c2 stall_mem", stall_mem, 1'b0);
    tick(); dm_req = 1'b0;
    tick();

    // Contention: store wins, fetch issued two cycles after dm_ack
    rd_val = 32'h0;
    exp_q.push_back(mk(1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678));
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'h12345678;
    smp(); tick(); smp();
    chk1("t2 store mem_we", mem_we, 1'b1);
    chk32("t2 store mem_be", 32'(mem_be), 32'h3);
    chk32("t2 store mem_addr", mem_addr, 32'h200);
    chk32("t2 store mem_wdata", mem_wdata, 32'h12345678);
    wait_for("t2 dm_ack", 1, 10, n);
    tick(); dm_req = 1'b0; dm_we = 1'b0; rd_val = 32'h00000093;
    smp(); chk1("t2 gap mem_req", mem_req, 1'b0);
    tick(); smp();
    chk1("t2 fetch mem_req", mem_req, 1'b1); chk32("t2 fetch mem_addr", mem_addr, 32'h40);
    wait_for("t2 if_ack", 0, 10, n);
    chk32("t2 if_rdata", if_rdata, 32'h93);
    tick(); if_req = 1'b0;
    tick();

    // Kill while the fetch is in RESP
    rvalid_delay = 2; rd_val = 32'h13;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    if_req = 1'b1; if_addr = 32'h40;
    smp(); tick(); smp(); chk1("t3 mem_req", mem_req, 1'b1);
    tick(); if_kill = 1'b1; if_req = 1'b0;
    smp(); chk1("t3 kill cycle if_ack", if_ack, 1'b0);
    tick(); if_kill = 1'b0;
    smp(); tick(); smp();
    chk1("t3 rvalid cycle if_ack", if_ack, 1'b0);
    tick();
    rvalid_delay = 0; rd_val = 32'h99;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h80, 32'h0));
    if_req = 1'b1; if_addr = 32'h80;
    wait_for("t3 refetch", 0, 10, n);
    chk32("t3 refetch latency", 32'(n), 32'd3);
    chk32("t3 refetch rdata", if_rdata, 32'h99);
    tick(); if_req = 1'b0;
    tick();

    // Kill coinciding with rvalid
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'hC0, 32'h0));
    if_req = 1'b1; if_addr = 32'hC0;
    smp(); tick(); smp(); tick();
    if_kill = 1'b1; if_req = 1'b0;
    smp(); chk1("t3b if_ack", if_ack, 1'b0); chk1("t3b stall_if", stall_if, 1'b0);
    tick(); if_kill = 1'b0;
    tick();

    // Response timeout
    rvalid_delay = 99; rd_val = 32'hAAAA5555;
    exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h300, 32'h0));
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300;
    smp(); tick(); smp(); chk1("t4 accept", mem_req & mem_ready, 1'b1);
    wait_for("t4 dm_ack", 1, 10, n);
    chk32("t4 timeout latency", 32'(n), 32'd4);
    chk1("t4 bus_err", bus_err, 1'b1);
    chk32("t4 dm_rdata", dm_rdata, 32'h0);
    tick(); dm_req = 1'b0;
    tick();

    // Reset while waiting in RESP, then a stale response
    rvalid_delay = 99; rd_val = 32'h5555;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    if_req = 1'b1; if_addr = 32'h40;
    smp(); tick(); smp(); tick(); smp(); tick();
    rst = 1'b1; if_req = 1'b0;
    exp_q.delete(); cur_valid = 1'b0; kill_flag = 1'b0;
    #1;
    chk1("t5 async mem_req", mem_req, 1'b0);
    chk1("t5 async if_ack", if_ack, 1'b0);
    tick(); tick(); rst = 1'b0;
    tick(); force_rvalid = 1'b1;
    smp();
    chk1("t5 stale if_ack", if_ack, 1'b0);
    chk1("t5 stale dm_ack", dm_ack, 1'b0);
    chk1("t5 stale bus_err", bus_err, 1'b0);
    chk32("t5 stale if_rdata", if_rdata, 32'h0);
    chk1("t5 stale mem_req", mem_req, 1'b0);
    tick(); force_rvalid = 1'b0;
    tick();
    rvalid_delay = 0; rd_val = 32'h13;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hF, 32'h40, 32'h0));
    if_req = 1'b1; if_addr = 32'h40;
    wait_for("t5 fetch", 0, 10, n);
    chk32("t5 fetch latency", 32'(n), 32'd3);
    chk32("t5 fetch rdata", if_rdata, 32'h13);
    tick(); if_req = 1'b0;
    tick();

    // Slow accept: five cycles of mem_ready low
    ready_delay = 5; rvalid_delay = 0; rd_val = 32'hCAFEF00D;
    exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h500, 32'h0));
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h500;
    stall_cnt = 0; req_cnt = 0; got_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (stall_mem) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        chk32("t6 mem_addr stable", mem_addr, 32'h500);
      end
      if (dm_ack) begin
        got_ack = 1'b1;
        chk32("t6 dm_rdata", dm_rdata, 32'hCAFEF00D);
        break;
      end
      tick();
    end
    chk1("t6 dm_ack seen", got_ack, 1'b1);
    chk32("t6 mem_req cycles", 32'(req_cnt), 32'd6);
    chk32("t6 stall cycles", 32'(stall_cnt), 32'd7);
    tick(); dm_req = 1'b0; ready_delay = 0;
    tick(); tick();

    chk32("model queue drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
